// File: rtl/axil_rr_master_arbiter_if.sv
// axil_rr_master_arbiter_if: AXI4-Lite bus bundle between the arbiter and its slave
interface axil_rr_master_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 4
);
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_rr_master_arbiter.sv
// axil_rr_master_arbiter: two-requester round-robin arbiter issuing one AXI4-Lite transaction at a time
module axil_rr_master_arbiter #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 4
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic                        r0_req,
   input  logic                        r0_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0] r0_addr,
   input  logic [C_AXI_DATA_WIDTH-1:0] r0_wdata,
   output logic                        r0_done,
   output logic [C_AXI_DATA_WIDTH-1:0] r0_rdata,
   output logic [1:0]                  r0_resp,
   input  logic                        r1_req,
   input  logic                        r1_we,
   input  logic [C_AXI_ADDR_WIDTH-1:0] r1_addr,
   input  logic [C_AXI_DATA_WIDTH-1:0] r1_wdata,
   output logic                        r1_done,
   output logic [C_AXI_DATA_WIDTH-1:0] r1_rdata,
   output logic [1:0]                  r1_resp,
   output logic                        busy,
   axil_rr_master_arbiter_if.master    m_axi
);
   localparam logic [C_AXI_ADDR_WIDTH-1:0] AMASK = {{(C_AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};
   typedef enum logic [2:0] {IDLE, WR_AW, WR_B, RD_AR, RD_R, DONE} state_t;
   state_t st;
   logic last_grant, gnt, aw_seen, w_seen, pick, sel_we, aw_ok, w_ok;
   logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
   logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
   logic [1:0] done;
   always_comb begin
      pick = (r0_req & r1_req) ? ~last_grant : r1_req;
      sel_we = pick ? r1_we : r0_we;
      aw_ok = aw_seen | (m_axi.awvalid & m_axi.awready);
      w_ok = w_seen | (m_axi.wvalid & m_axi.wready);
   end
   assign m_axi.awaddr = addr_q;
   assign m_axi.araddr = addr_q;
   assign m_axi.awprot = '0;
   assign m_axi.arprot = '0;
   assign m_axi.wdata = wdata_q;
   assign m_axi.wstrb = '1;
   assign r0_done = done[0];
   assign r1_done = done[1];
   assign busy = st != IDLE;
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         st <= IDLE;
         last_grant <= 1'b1;
         gnt <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         aw_seen <= 1'b0;
         w_seen <= 1'b0;
         done <= '0;
         m_axi.awvalid <= 1'b0;
         m_axi.wvalid <= 1'b0;
         m_axi.bready <= 1'b0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready <= 1'b0;
         r0_rdata <= '0;
         r1_rdata <= '0;
         r0_resp <= '0;
         r1_resp <= '0;
      end else begin
         done <= '0;
         case (st)
            IDLE: if (r0_req | r1_req) begin
               gnt <= pick;
               last_grant <= pick;
               addr_q <= (pick ? r1_addr : r0_addr) & AMASK;
               wdata_q <= pick ? r1_wdata : r0_wdata;
               st <= sel_we ? WR_AW : RD_AR;
               m_axi.awvalid <= sel_we;
               m_axi.wvalid <= sel_we;
               m_axi.arvalid <= ~sel_we;
            end
            WR_AW: begin
               // AW and W complete independently; leave only once both have been accepted
               if (m_axi.awvalid & m_axi.awready) begin
                  m_axi.awvalid <= 1'b0;
                  aw_seen <= 1'b1;
               end
               if (m_axi.wvalid & m_axi.wready) begin
                  m_axi.wvalid <= 1'b0;
                  w_seen <= 1'b1;
               end
               if (aw_ok & w_ok) begin
                  aw_seen <= 1'b0;
                  w_seen <= 1'b0;
                  m_axi.bready <= 1'b1;
                  st <= WR_B;
               end
            end
            WR_B: if (m_axi.bvalid) begin
               m_axi.bready <= 1'b0;
               done[gnt] <= 1'b1;
               if (gnt) r1_resp <= m_axi.bresp;
               else r0_resp <= m_axi.bresp;
               st <= DONE;
            end
            RD_AR: if (m_axi.arready) begin
               m_axi.arvalid <= 1'b0;
               m_axi.rready <= 1'b1;
               st <= RD_R;
            end
            RD_R: if (m_axi.rvalid) begin
               m_axi.rready <= 1'b0;
               done[gnt] <= 1'b1;
               if (gnt) begin
                  r1_rdata <= m_axi.rdata;
                  r1_resp <= m_axi.rresp;
               end else begin
                  r0_rdata <= m_axi.rdata;
                  r0_resp <= m_axi.rresp;
               end
               st <= DONE;
            end
            DONE: st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axil_rr_master_arbiter.sv
// tb_axil_rr_master_arbiter: directed bench with a small AXI4-Lite register slave
module tb_axil_rr_master_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic r0_req, r0_we, r0_done, r1_req, r1_we, r1_done, busy;
   logic [3:0] r0_addr, r1_addr;
   logic [31:0] r0_wdata, r0_rdata, r1_wdata, r1_rdata;
   logic [1:0] r0_resp, r1_resp;
   int checks = 0;
   int failures = 0;
   axil_rr_master_arbiter_if #(.DW(32), .AW(4)) bus ();
   axil_rr_master_arbiter #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(4)) dut (
      .ACLK(clk), .ARESET(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_resp(r0_resp),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_resp(r1_resp),
      .busy(busy), .m_axi(bus)
   );
   logic [31:0] mem [4];
   int aw_wait = 0;
   int aw_cnt;
   logic [1:0] bresp_k = 2'b00;
   logic [1:0] rresp_k = 2'b00;
   logic aw_got, w_got, got_a, got_w;
   logic [1:0] wa, wr_a;
   logic [31:0] wd, wr_d;
   assign bus.awready = bus.awvalid && aw_cnt == 0;
   assign bus.wready = bus.wvalid;
   assign bus.arready = bus.arvalid;
   assign got_a = aw_got | (bus.awvalid & bus.awready);
   assign got_w = w_got | (bus.wvalid & bus.wready);
   assign wr_a = aw_got ? wa : bus.awaddr[3:2];
   assign wr_d = w_got ? wd : bus.wdata;
   always @(posedge clk) begin
      if (rst) begin
         aw_got <= 1'b0;
         w_got <= 1'b0;
         aw_cnt <= 0;
         wa <= '0;
         wd <= '0;
         bus.bvalid <= 1'b0;
         bus.bresp <= 2'b00;
         bus.rvalid <= 1'b0;
         bus.rresp <= 2'b00;
         bus.rdata <= '0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         if (!bus.awvalid) aw_cnt <= aw_wait;
         else if (aw_cnt != 0) aw_cnt <= aw_cnt - 1;
         if (bus.awvalid & bus.awready) begin
            aw_got <= 1'b1;
            wa <= bus.awaddr[3:2];
         end
         if (bus.wvalid & bus.wready) begin
            w_got <= 1'b1;
            wd <= bus.wdata;
         end
         if (got_a & got_w & !bus.bvalid) begin
            mem[wr_a] <= wr_d;
            bus.bvalid <= 1'b1;
            bus.bresp <= bresp_k;
            aw_got <= 1'b0;
            w_got <= 1'b0;
         end
         if (bus.bvalid & bus.bready) bus.bvalid <= 1'b0;
         if (bus.arvalid) begin
            bus.rvalid <= 1'b1;
            bus.rdata <= mem[bus.araddr[3:2]];
            bus.rresp <= rresp_k;
         end
         if (bus.rvalid & bus.rready) bus.rvalid <= 1'b0;
      end
   end
   int awv_n = 0, wv_n = 0, bhs_n = 0, d0_n = 0, d1_n = 0, dbl = 0;
   logic p0 = 1'b0, p1 = 1'b0;
   logic [3:0] last_aw = '0, last_ar = '0;
   always @(negedge clk) begin
      if (bus.awvalid) awv_n <= awv_n + 1;
      if (bus.wvalid) wv_n <= wv_n + 1;
      if (bus.bvalid & bus.bready) bhs_n <= bhs_n + 1;
      if (r0_done) d0_n <= d0_n + 1;
      if (r1_done) d1_n <= d1_n + 1;
      if ((r0_done & p0) | (r1_done & p1)) dbl <= dbl + 1;
      p0 <= r0_done;
      p1 <= r1_done;
      if (bus.awvalid) last_aw <= bus.awaddr;
      if (bus.arvalid) last_ar <= bus.araddr;
   end
   int ord [8];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
      chk("rst_done", {r0_done, r1_done}, 0);
      chk("rst_rdata0", r0_rdata, 0);
      chk("rst_rdata1", r1_rdata, 0);
      chk("rst_resp", {r0_resp, r1_resp}, 0);
      rst = 1'b0;
   endtask
   task automatic cmd(input bit n, input bit we, input logic [3:0] a, input logic [31:0] d, output int cyc);
      bit got = 0;
      @(negedge clk);
      if (n) begin
         r1_we = we; r1_addr = a; r1_wdata = d; r1_req = 1'b1;
      end else begin
         r0_we = we; r0_addr = a; r0_wdata = d; r0_req = 1'b1;
      end
      cyc = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         got = n ? r1_done : r0_done;
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      chk("cmd_timeout", 32'(got), 1);
   endtask
   task automatic run_pair(input int total, input bit hold, input bit we0, input logic [3:0] a0,
                           input logic [31:0] d0, input bit we1, input logic [3:0] a1, input logic [31:0] d1);
      int nd = 0;
      int cyc = 0;
      @(negedge clk);
      r0_we = we0; r0_addr = a0; r0_wdata = d0; r0_req = 1'b1;
      r1_we = we1; r1_addr = a1; r1_wdata = d1; r1_req = 1'b1;
      while (nd < total && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (r0_done) begin
            ord[nd] = 0; nd++;
            if (!hold) r0_req = 1'b0;
         end
         if (r1_done) begin
            ord[nd] = 1; nd++;
            if (!hold) r1_req = 1'b0;
         end
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      chk("pair_count", nd, total);
   endtask
   initial begin
      int cyc, k, s_aw, s_w, s_b, s_d0;
      rst = 1'b1;
      r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
      r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
      reset_dut();
      chk("const_prot", {bus.awprot, bus.arprot}, 0);
      chk("const_wstrb", bus.wstrb, 4'hf);
      // test 1: write then read back, zero-wait latency
      s_d0 = d0_n;
      cmd(0, 1, 4'h0, 32'h1, cyc);
      chk("t1_wr_lat", cyc, 3);
      chk("t1_bresp", r0_resp, 2'b00);
      cmd(0, 0, 4'h0, 32'h0, cyc);
      chk("t1_rd_lat", cyc, 3);
      chk("t1_rdata", r0_rdata, 32'h1);
      chk("t1_rresp", r0_resp, 2'b00);
      @(negedge clk);
      chk("t1_done_cnt", d0_n - s_d0, 2);
      chk("t1_done_width", dbl, 0);
      // error responses pass through; writes leave rdata alone
      rresp_k = 2'b10;
      cmd(0, 0, 4'h0, 32'h0, cyc);
      chk("err_rresp", r0_resp, 2'b10);
      chk("err_rdata", r0_rdata, 32'h1);
      rresp_k = 2'b00;
      bresp_k = 2'b11;
      cmd(0, 1, 4'h8, 32'hCAFE, cyc);
      chk("err_bresp", r0_resp, 2'b11);
      chk("wr_keeps_rdata", r0_rdata, 32'h1);
      bresp_k = 2'b00;
      // test 2: simultaneous writes out of reset, r0 first
      reset_dut();
      run_pair(2, 0, 1, 4'h4, 32'hA, 1, 4'h8, 32'hB);
      chk("t2_first", ord[0], 0);
      chk("t2_second", ord[1], 1);
      cmd(0, 0, 4'h4, 0, cyc);
      chk("t2_rd_a", r0_rdata, 32'hA);
      cmd(1, 0, 4'h8, 0, cyc);
      chk("t2_rd_b", r1_rdata, 32'hB);
      // test 3: both hold back-to-back reads, grants alternate
      cmd(1, 1, 4'hC, 32'h12345678, cyc);
      run_pair(4, 1, 0, 4'hC, 0, 0, 4'hC, 0);
      chk("t3_g0", ord[0], 0);
      chk("t3_g1", ord[1], 1);
      chk("t3_g2", ord[2], 0);
      chk("t3_g3", ord[3], 1);
      chk("t3_rd0", r0_rdata, 32'h12345678);
      chk("t3_rd1", r1_rdata, 32'h12345678);
      // test 4: AWREADY stalled 3 cycles, WREADY immediate
      aw_wait = 3;
      @(negedge clk);
      s_aw = awv_n; s_w = wv_n; s_b = bhs_n; s_d0 = d0_n;
      cmd(0, 1, 4'h0, 32'hDEADBEEF, cyc);
      @(negedge clk);
      chk("t4_awvalid_cycles", awv_n - s_aw, 4);
      chk("t4_wvalid_cycles", wv_n - s_w, 1);
      chk("t4_b_handshakes", bhs_n - s_b, 1);
      chk("t4_done_cnt", d0_n - s_d0, 1);
      aw_wait = 0;
      cmd(0, 0, 4'h0, 0, cyc);
      chk("t4_rdata", r0_rdata, 32'hDEADBEEF);
      // test 5: reset while waiting for B
      @(negedge clk);
      r0_we = 1; r0_addr = 4'h8; r0_wdata = 32'h77; r0_req = 1'b1;
      k = 0;
      while (!bus.bready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t5_reach_wr_b", bus.bready, 1);
      s_d0 = d0_n;
      rst = 1'b1;
      r0_req = 1'b0;
      @(negedge clk);
      chk("t5_valids", {bus.awvalid, bus.wvalid, bus.bready}, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", r0_done, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_no_done", d0_n - s_d0, 0);
      run_pair(2, 0, 0, 4'h0, 0, 0, 4'h0, 0);
      chk("t5_tie_first", ord[0], 0);
      chk("t5_tie_second", ord[1], 1);
      cmd(1, 0, 4'h0, 0, cyc);
      chk("t5_rd_lat", cyc, 3);
      chk("t5_rresp", r1_resp, 2'b00);
      // test 6: unaligned address is word-forced
      cmd(1, 1, 4'h0, 32'h99, cyc);
      cmd(1, 0, 4'h0, 0, cyc);
      chk("t6_rd_99", r1_rdata, 32'h99);
      cmd(1, 1, 4'h7, 32'h55, cyc);
      chk("t6_awaddr", last_aw, 4'h4);
      chk("t6_wr_keeps_rdata", r1_rdata, 32'h99);
      cmd(1, 0, 4'h6, 0, cyc);
      chk("t6_araddr", last_ar, 4'h4);
      chk("t6_rdata", r1_rdata, 32'h55);
      chk("t6_rresp", r1_resp, 2'b00);
      @(negedge clk);
      chk("done_width_all", dbl, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axil_rr_master_arbiter.md
Name: axil_rr_master_arbiter

Overview:
- Two-requester round-robin arbiter and AXI4-Lite master sequencer in front of the myLED slave register block (4 x 32-bit registers, word-aligned at 0x0/0x4/0x8/0xC).
- Each requester issues single-word read or write commands over a req/done interface.
- The block serialises these commands into AXI4-Lite transactions, one outstanding at a time, and returns read data and response per requester.

Parameters:
C_AXI_DATA_WIDTH, 32, data width of AXI bus and requester data
C_AXI_ADDR_WIDTH, 4, byte address width (4 registers)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
rN_req  in  1  command request, N=0,1; held until done
rN_we  in  1  1=write, 0=read
rN_addr  in  C_AXI_ADDR_WIDTH  byte address
rN_wdata  in  C_AXI_DATA_WIDTH  write data
rN_done  out  1  one-cycle completion pulse
rN_rdata  out  C_AXI_DATA_WIDTH  read data, valid from done until next done of same N
rN_resp  out  2  captured BRESP/RRESP, same validity as rdata
busy  out  1  high in any state other than IDLE
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master, widths per parameters

Behaviour:
- Clock ACLK; reset ARESET is synchronous and active-high.
- Reset values: all VALID/READY 0, rN_done 0, rN_rdata 0, rN_resp 0, busy 0, state IDLE, last_grant=1 so r0 wins the first tie.
- Constant outputs: AWPROT/ARPROT = 3'b000; WSTRB all ones.
- Address is word-forced: {addr[ADDR_W-1:2], 2'b00}.
- FSM states: IDLE, WR_AW, WR_B, RD_AR, RD_R, DONE.
- IDLE:
  - Samples req at each edge.
  - One requester active: grant it. Both active: grant the one != last_grant.
  - On grant: latch we/addr/wdata and requester index, update last_grant, go to WR_AW if we else RD_AR.
- WR_AW:
  - AWVALID and WVALID assert together on entry.
  - Each drops on the edge after its own handshake, independently; either may complete first.
  - When both handshakes have occurred (same or different cycles), go to WR_B.
- WR_B: BREADY=1. On BVALID&BREADY, capture BRESP into rN_resp; go to DONE.
- RD_AR: ARVALID=1 until ARREADY; then go to RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA/RRESP into rN_rdata/rN_resp; go to DONE.
- DONE:
  - Granted rN_done=1 for exactly one cycle, then return to IDLE.
  - Requester must deassert req (or present a new command) at the edge where it samples done=1.
- VALIDs never drop before handshake; latched fields are stable while VALID.
- Minimum latency, zero-wait slave, req sampled to done:
  - Write: 3 cycles (WR_AW, WR_B, DONE).
  - Read: 3 cycles when RVALID arrives the cycle after ARREADY.
- Error responses (SLVERR/DECERR) are passed through unchanged; no retry.
- Ungranted requester's req is ignored until next IDLE; its rdata/resp hold.
- Reset mid-operation: next edge forces IDLE and all VALID/READY low. No done pulse; outstanding command is abandoned; requester must re-issue. last_grant returns to 1.
- Read data captured for a write is not altered: writes update only resp.

Test Plan:
1. r0 write 0x00000001 @0x0, then r0 read @0x0 -> each done pulse exactly 1 cycle; rdata=0x00000001, resp=2'b00.
2. Out of reset, r0 write 0xA @0x4 and r1 write 0xB @0x8 requested same cycle -> r0 served first, then r1; readbacks return 0xA and 0xB.
3. r0 and r1 each hold back-to-back reads @0xC -> grants alternate r0,r1,r0,r1 over 4 transactions; no requester served twice in a row while the other waits.
4. Slave holds AWREADY low 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles; one B handshake; single done.
5. ARESET pulsed while in WR_B -> next cycle AWVALID=WVALID=BREADY=0, busy=0, no done. After release, r1 read @0x0 completes with resp=2'b00.
6. r1 write 0x55 @addr 0x7 -> AWADDR=0x4; read @0x4 returns 0x55.
